// File: rtl/clk_wave_sched.sv
// Two-waveform scheduler: programmable period/high/phase in clk cycles, config
// over valid/ready, mid-run updates deferred to the period wrap (no runt pulses).
module clk_wave_sched #(
  parameter int CNT_W      = 8,
  parameter int DEF_PERIOD = 10,
  parameter int DEF_HIGH   = 5,
  parameter int DEF_PHASE  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             cfg_err,
  output logic             wave0,
  output logic             wave1,
  output logic             period_start,
  output logic             active
);

  typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] phase;
  } cfg_t;

  localparam cfg_t DEF_CFG = '{period: CNT_W'(DEF_PERIOD),
                               high:   CNT_W'(DEF_HIGH),
                               phase:  CNT_W'(DEF_PHASE)};

  state_t           state, state_n;
  cfg_t             act, act_n, pend, pend_n, cfg_in;
  logic             has_pend, has_pend_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             xfer, legal, take, wrap, gen_n;
  logic [CNT_W:0]   d_n;

  assign cfg_in    = '{period: cfg_period, high: cfg_high, phase: cfg_phase};
  assign cfg_ready = (state == IDLE) || (state == RUN);
  assign active    = (state != IDLE);
  assign xfer      = cfg_valid && cfg_ready;
  assign legal     = (cfg_period >= CNT_W'(2)) && (cfg_high != '0) &&
                     (cfg_high < cfg_period) && (cfg_phase < cfg_period);
  assign take      = xfer && legal;
  assign wrap      = (cnt == act.period - CNT_W'(1));
  assign cnt_inc   = wrap ? '0 : cnt + CNT_W'(1);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    act_n      = act;
    pend_n     = pend;
    has_pend_n = has_pend;
    case (state)
      IDLE: begin
        if (take) act_n = cfg_in;
        if (en) begin
          state_n = RUN;
          cnt_n   = '0;
        end
      end
      RUN: begin
        cnt_n = cnt_inc;
        if (take) begin
          pend_n     = cfg_in;
          has_pend_n = 1'b1;
        end
        if (!en)       state_n = STOP;
        else if (take) state_n = PEND;
      end
      PEND: begin
        cnt_n = cnt_inc;
        if (wrap) begin
          act_n      = pend;
          has_pend_n = 1'b0;
          state_n    = en ? RUN : STOP;
        end
      end
      default: begin // STOP: finish the current period, re-arm if en returns
        cnt_n = cnt_inc;
        if (wrap) begin
          if (has_pend) act_n = pend;
          has_pend_n = 1'b0;
          state_n    = en ? RUN : IDLE;
        end else if (en) begin
          state_n = has_pend ? PEND : RUN;
        end
      end
    endcase
  end

  // Wave flops are computed from the next cnt/config so they line up with cnt.
  assign gen_n = (state_n != IDLE);
  assign d_n   = ({1'b0, cnt_n} >= {1'b0, act_n.phase}) ?
                 {1'b0, cnt_n} - {1'b0, act_n.phase} :
                 {1'b0, cnt_n} + {1'b0, act_n.period} - {1'b0, act_n.phase};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      act          <= DEF_CFG;
      pend         <= '0;
      has_pend     <= 1'b0;
      cfg_err      <= 1'b0;
      wave0        <= 1'b0;
      wave1        <= 1'b0;
      period_start <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      act          <= act_n;
      pend         <= pend_n;
      has_pend     <= has_pend_n;
      cfg_err      <= xfer && !legal;
      wave0        <= gen_n && (cnt_n < act_n.high);
      wave1        <= gen_n && (d_n < {1'b0, act_n.high});
      period_start <= gen_n && (cnt_n == '0);
    end
  end

endmodule

// File: tb/tb_clk_wave_sched.sv
// Self-checking bench for clk_wave_sched: directed scenarios plus random
// en/config traffic against a cycle-level behavioural model.
module tb_clk_wave_sched;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_period = '0, cfg_high = '0, cfg_phase = '0;
  logic         cfg_ready, cfg_err, wave0, wave1, period_start, active;
  logic [5:0]   outs;

  int n_cmp = 0;
  int n_fail = 0;

  clk_wave_sched #(.CNT_W(W), .DEF_PERIOD(10), .DEF_HIGH(5), .DEF_PHASE(5)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .cfg_phase(cfg_phase),
    .cfg_err(cfg_err), .wave0(wave0), .wave1(wave1),
    .period_start(period_start), .active(active));

  always #5 clk = ~clk;

  assign outs = {wave0, wave1, period_start, active, cfg_ready, cfg_err};

  // Behavioural model: mode 0 idle, 1 running, 2 running with update queued,
  // 3 finishing last period.
  typedef struct {int per; int hi; int ph;} mcfg_t;
  mcfg_t pend_q[$];
  mcfg_t act_c;
  int    m_mode, m_cnt;
  bit    m_err;

  function automatic void m_reset();
    m_mode = 0; m_cnt = 0; m_err = 0;
    act_c = '{per: 10, hi: 5, ph: 5};
    pend_q.delete();
  endfunction

  function automatic void m_apply();
    if (pend_q.size() > 0) act_c = pend_q.pop_front();
  endfunction

  function automatic void m_step(bit e, bit v, int p, int h, int ph);
    bit rdy, xf, ok, wr;
    rdy = (m_mode == 0 || m_mode == 1);
    xf  = v && rdy;
    ok  = (p >= 2) && (h >= 1) && (h < p) && (ph < p);
    m_err = xf && !ok;
    wr  = (m_cnt == act_c.per - 1);
    case (m_mode)
      0: begin
        if (xf && ok) act_c = '{per: p, hi: h, ph: ph};
        if (e) begin m_mode = 1; m_cnt = 0; end
      end
      1: begin
        if (xf && ok) pend_q.push_back('{per: p, hi: h, ph: ph});
        m_cnt = wr ? 0 : m_cnt + 1;
        if (!e) m_mode = 3;
        else if (pend_q.size() > 0) m_mode = 2;
      end
      2: begin
        if (wr) begin m_apply(); m_cnt = 0; m_mode = e ? 1 : 3; end
        else m_cnt++;
      end
      default: begin
        if (wr) begin m_apply(); m_cnt = 0; m_mode = e ? 1 : 0; end
        else begin
          m_cnt++;
          if (e) m_mode = (pend_q.size() > 0) ? 2 : 1;
        end
      end
    endcase
  endfunction

  function automatic logic [5:0] exp_vec();
    bit g;
    int lag;
    g   = (m_mode != 0);
    lag = (m_cnt + act_c.per - act_c.ph) % act_c.per;
    return {g && (m_cnt < act_c.hi), g && (lag < act_c.hi), g && (m_cnt == 0),
            g, (m_mode == 0 || m_mode == 1), m_err};
  endfunction

  // Advance one clock; model sees the same inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    m_step(en, cfg_valid, int'(cfg_period), int'(cfg_high), int'(cfg_phase));
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0;
    #2;
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic set_cfg(input bit v, input int p, input int h, input int ph);
    cfg_valid = v; cfg_period = W'(p); cfg_high = W'(h); cfg_phase = W'(ph);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    m_reset();
    n_cmp++;
    if (outs !== 6'b000010) begin
      n_fail++;
      $display("FAIL reset: outs=%b want 000010", outs);
    end
    do_reset();
    n_cmp++;
    if (outs !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_idle: outs=%b want %b", outs, exp_vec());
    end
  endtask

  task automatic test_default();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      n_cmp++;
      if (outs !== exp_vec()) begin
        n_fail++;
        $display("FAIL default c%0d: outs=%b want %b", i, outs, exp_vec());
      end
    end
    n_cmp++;
    if (wave1 !== ~wave0) begin
      n_fail++;
      $display("FAIL default_inv: wave0=%b wave1=%b want inverse", wave0, wave1);
    end
  endtask

  task automatic test_idle_cfg();
    do_reset();
    set_cfg(1, 20, 8, 0);
    en = 1'b1;
    for (int i = 0; i < 45; i++) begin
      tick();
      cfg_valid = 1'b0;
      n_cmp++;
      if (outs !== exp_vec() || wave0 !== wave1) begin
        n_fail++;
        $display("FAIL idle_cfg c%0d: outs=%b want %b", i, outs, exp_vec());
      end
    end
  endtask

  task automatic test_pend();
    int guard;
    do_reset();
    en = 1'b1;
    guard = 0;
    while (!(m_mode == 1 && m_cnt == 3) && guard < 50) begin tick(); guard++; end
    n_cmp++;
    if (guard >= 50) begin
      n_fail++;
      $display("FAIL pend_wait: cnt=%0d want 3", m_cnt);
    end
    set_cfg(1, 6, 3, 2);
    for (int i = 0; i < 30; i++) begin
      tick();
      cfg_valid = 1'b0;
      n_cmp++;
      if (outs !== exp_vec()) begin
        n_fail++;
        $display("FAIL pend c%0d: outs=%b want %b", i, outs, exp_vec());
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    set_cfg(1, 10, 10, 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      cfg_valid = 1'b0;
      n_cmp++;
      if (outs !== exp_vec() || (i == 0 && cfg_err !== 1'b1) || (i > 0 && cfg_err !== 1'b0)) begin
        n_fail++;
        $display("FAIL illegal c%0d: outs=%b want %b", i, outs, exp_vec());
      end
    end
  endtask

  task automatic test_stop();
    int guard;
    for (int rep = 0; rep < 2; rep++) begin
      do_reset();
      en = 1'b1;
      guard = 0;
      while (m_cnt != 3 && guard < 50) begin tick(); guard++; end
      en = 1'b0;
      for (int i = 0; i < 15; i++) begin
        if (rep == 1 && m_cnt == 6) en = 1'b1;
        tick();
        n_cmp++;
        if (outs !== exp_vec()) begin
          n_fail++;
          $display("FAIL stop r%0d c%0d: outs=%b want %b", rep, i, outs, exp_vec());
        end
      end
      n_cmp++;
      if (active !== (rep == 1)) begin
        n_fail++;
        $display("FAIL stop_end r%0d: active=%b want %0d", rep, active, rep);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    set_cfg(1, 4, 1, 0);
    tick();
    cfg_valid = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    n_cmp++;
    if ({wave0, wave1, period_start, active, cfg_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL async_rst: outs=%b want 00000", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      n_cmp++;
      if (outs !== exp_vec()) begin
        n_fail++;
        $display("FAIL async_rst_run c%0d: outs=%b want %b", i, outs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    int p;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 7) == 0) begin
        p = $urandom_range(0, 15);
        set_cfg(1, p, $urandom_range(0, p), $urandom_range(0, p));
      end else cfg_valid = 1'b0;
      tick();
      n_cmp++;
      if (outs !== exp_vec()) begin
        n_fail++;
        $display("FAIL random c%0d: outs=%b want %b", i, outs, exp_vec());
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_default();
    test_idle_cfg();
    test_pend();
    test_illegal();
    test_stop();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
